// File: rtl/deserializer_if.sv
// rtl/deserializer_if.sv - serial bit stream and assembled word bundle for the deserializer
// Optional oParity_err signal present when PARITY_CHECK_EN is defined.
interface deserializer_if #(
   parameter int MSG_SIZE = 64
);
   localparam int CW = $clog2(MSG_SIZE) + 1;

   logic                iData_in;
   logic                iData_flag;
   logic                iClear;
   logic [MSG_SIZE-1:0] oData_out;
   logic [CW-1:0]       oCounter;
   logic                oData_valid;
   logic                oOverrun;
`ifdef PARITY_CHECK_EN
   logic                oParity_err;

   modport master (
      output iData_in, iData_flag, iClear,
      input  oData_out, oCounter, oData_valid, oOverrun, oParity_err
   );

   modport slave (
      input  iData_in, iData_flag, iClear,
      output oData_out, oCounter, oData_valid, oOverrun, oParity_err
   );
`else
   modport master (
      output iData_in, iData_flag, iClear,
      input  oData_out, oCounter, oData_valid, oOverrun
   );

   modport slave (
      input  iData_in, iData_flag, iClear,
      output oData_out, oCounter, oData_valid, oOverrun
   );
`endif
endinterface

// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel word collector held until consumer clear
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per word and report oParity_err.
module deserializer #(
   parameter int MSG_SIZE = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   deserializer_if.slave   bus
);
   localparam int CW = $clog2(MSG_SIZE) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FULL   = 2'd2,
      ST_PARITY = 2'd3
   } state_t;

   state_t              r_state;
   logic [MSG_SIZE-1:0] r_data;
   logic [CW-1:0]       r_count;
   logic                r_valid;
   logic                r_overrun;

   state_t              w_state_nxt;
   logic [MSG_SIZE-1:0] w_data_nxt;
   logic [CW-1:0]       w_count_nxt;
   logic                w_valid_nxt;
   logic                w_overrun_nxt;
   logic                w_restart;
   logic                w_last;
   logic [MSG_SIZE-1:0] w_first_word;

`ifdef PARITY_CHECK_EN
   logic                r_perr;
   logic                w_perr_nxt;
`endif

   assign w_last       = (r_count == CW'(MSG_SIZE - 1));
   assign w_first_word = {{(MSG_SIZE-1){1'b0}}, bus.iData_in};

   always_comb begin
      w_state_nxt   = r_state;
      w_data_nxt    = r_data;
      w_count_nxt   = r_count;
      w_valid_nxt   = r_valid;
      w_overrun_nxt = r_overrun;
      w_restart     = 1'b0;
`ifdef PARITY_CHECK_EN
      w_perr_nxt    = r_perr;
`endif

      case (r_state)
         ST_IDLE, ST_SHIFT: begin
            if (bus.iClear) begin
               w_restart = 1'b1;
            end else if (bus.iData_flag) begin
               w_data_nxt = {r_data[MSG_SIZE-2:0], bus.iData_in};
               if (w_last) begin
`ifdef PARITY_CHECK_EN
                  // Counter stays at MSG_SIZE-1 until the parity bit lands.
                  w_state_nxt = ST_PARITY;
`else
                  w_count_nxt = r_count + CW'(1);
                  w_valid_nxt = 1'b1;
                  w_state_nxt = ST_FULL;
`endif
               end else begin
                  w_count_nxt = r_count + CW'(1);
                  w_state_nxt = ST_SHIFT;
               end
            end
         end
`ifdef PARITY_CHECK_EN
         ST_PARITY: begin
            if (bus.iClear) begin
               w_restart = 1'b1;
            end else if (bus.iData_flag) begin
               w_count_nxt = CW'(MSG_SIZE);
               w_valid_nxt = 1'b1;
               w_perr_nxt  = (^r_data) ^ bus.iData_in;
               w_state_nxt = ST_FULL;
            end
         end
`endif
         ST_FULL: begin
            if (bus.iClear) begin
               w_restart = 1'b1;
            end else if (bus.iData_flag) begin
               w_overrun_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // A clear empties the word; a same-cycle strobe starts the next frame.
      if (w_restart) begin
         w_valid_nxt = 1'b0;
`ifdef PARITY_CHECK_EN
         w_perr_nxt  = 1'b0;
`endif
         if (bus.iData_flag) begin
            w_data_nxt  = w_first_word;
            w_count_nxt = CW'(1);
            w_state_nxt = ST_SHIFT;
         end else begin
            w_data_nxt  = '0;
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_data    <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_perr    <= 1'b0;
`endif
      end else if (ena) begin
         r_state   <= w_state_nxt;
         r_data    <= w_data_nxt;
         r_count   <= w_count_nxt;
         r_valid   <= w_valid_nxt;
         r_overrun <= w_overrun_nxt;
`ifdef PARITY_CHECK_EN
         r_perr    <= w_perr_nxt;
`endif
      end
   end

   assign bus.oData_out   = r_data;
   assign bus.oCounter    = r_count;
   assign bus.oData_valid = r_valid;
   assign bus.oOverrun    = r_overrun;
`ifdef PARITY_CHECK_EN
   assign bus.oParity_err = r_perr;
`endif

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard bench for deserializer with MSG_SIZE=8
// Covers the parity variant when PARITY_CHECK_EN is defined.
module tb_deserializer;
   localparam int MSG_SIZE = 8;

   typedef struct {
      logic [7:0] data;
      logic [3:0] count;
   } exp_t;

   logic clk;
   logic rst_n;
   logic ena;
   int   checks;
   int   errors;
   logic prev_valid;
   exp_t sb_q[$];

   deserializer_if #(.MSG_SIZE(MSG_SIZE)) bus ();

   deserializer #(.MSG_SIZE(MSG_SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic f, input logic d, input logic c, input logic e);
      @(negedge clk);
      bus.iData_flag = f;
      bus.iData_in   = d;
      bus.iClear     = c;
      ena            = e;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_bits(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b1);
   endtask

   task automatic parity_bit(input logic [7:0] w);
`ifdef PARITY_CHECK_EN
      step(1'b1, ^w, 1'b0, 1'b1);
`else
      if (w === 8'hxx) $display("unused %0h", w);
`endif
   endtask

   task automatic send_word(input logic [7:0] w);
      send_bits(w);
      parity_bit(w);
   endtask

   task automatic push_exp(input logic [7:0] d);
      exp_t e;
      e.data  = d;
      e.count = 4'd8;
      sb_q.push_back(e);
   endtask

   // Monitor: every new word presented by the DUT is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.oData_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_word", {56'd0, bus.oData_out}, 64'hDEAD);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_word", {56'd0, bus.oData_out}, {56'd0, e.data});
               chk("sb_count", {60'd0, bus.oCounter}, {60'd0, e.count});
            end
         end
         prev_valid = bus.oData_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks         = 0;
      errors         = 0;
      prev_valid     = 1'b0;
      rst_n          = 1'b0;
      ena            = 1'b1;
      bus.iData_flag = 1'b0;
      bus.iData_in   = 1'b0;
      bus.iClear     = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_data", {56'd0, bus.oData_out}, 64'd0);
      chk("rst_count", {60'd0, bus.oCounter}, 64'd0);
      chk("rst_valid", {63'd0, bus.oData_valid}, 64'd0);
      chk("rst_overrun", {63'd0, bus.oOverrun}, 64'd0);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back frame 0xA5, valid one cycle after the last strobe.
      push_exp(8'hA5);
      send_word(8'hA5);
      idle(1);
      chk("t1_valid", {63'd0, bus.oData_valid}, 64'd1);
      chk("t1_data", {56'd0, bus.oData_out}, 64'hA5);
      chk("t1_count", {60'd0, bus.oCounter}, 64'd8);
      chk("t1_overrun", {63'd0, bus.oOverrun}, 64'd0);
      idle(2);
      chk("t1_hold", {56'd0, bus.oData_out}, 64'hA5);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
      chk("clr_count", {60'd0, bus.oCounter}, 64'd0);
      chk("clr_valid", {63'd0, bus.oData_valid}, 64'd0);
      chk("clr_data", {56'd0, bus.oData_out}, 64'd0);

      // Same frame with flag gaps and two disabled cycles carrying strobes.
      push_exp(8'hA5);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("gap_count5", {60'd0, bus.oCounter}, 64'd5);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      parity_bit(8'hA5);
      idle(1);
      chk("gap_data", {56'd0, bus.oData_out}, 64'hA5);
      chk("gap_count", {60'd0, bus.oCounter}, 64'd8);

      // Extra strobe while full: dropped, sticky overrun.
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(1);
      chk("ovr_data", {56'd0, bus.oData_out}, 64'hA5);
      chk("ovr_flag", {63'd0, bus.oOverrun}, 64'd1);
      chk("ovr_valid", {63'd0, bus.oData_valid}, 64'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
      chk("ovr_clr_count", {60'd0, bus.oCounter}, 64'd0);
      chk("ovr_clr_valid", {63'd0, bus.oData_valid}, 64'd0);
      chk("ovr_sticky", {63'd0, bus.oOverrun}, 64'd1);

      // Clear and strobe together while full: bit starts the next frame.
      push_exp(8'hA5);
      send_word(8'hA5);
      idle(1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("cs_count", {60'd0, bus.oCounter}, 64'd1);
      chk("cs_data", {56'd0, bus.oData_out}, 64'h01);
      chk("cs_valid", {63'd0, bus.oData_valid}, 64'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
      chk("abort_count", {60'd0, bus.oCounter}, 64'd0);

      // Asynchronous reset mid-frame, then a full 0x3C frame.
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);
      chk("mid_count", {60'd0, bus.oCounter}, 64'd4);
      chk("mid_data", {56'd0, bus.oData_out}, 64'h03);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", {56'd0, bus.oData_out}, 64'd0);
      chk("arst_count", {60'd0, bus.oCounter}, 64'd0);
      chk("arst_valid", {63'd0, bus.oData_valid}, 64'd0);
      chk("arst_overrun", {63'd0, bus.oOverrun}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(8'h3C);
      send_word(8'h3C);
      idle(1);
      chk("post_rst_data", {56'd0, bus.oData_out}, 64'h3C);
      chk("post_rst_valid", {63'd0, bus.oData_valid}, 64'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);

`ifdef PARITY_CHECK_EN
      push_exp(8'hA5);
      send_bits(8'hA5);
      idle(1);
      chk("par_wait_count", {60'd0, bus.oCounter}, 64'd7);
      chk("par_wait_valid", {63'd0, bus.oData_valid}, 64'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(1);
      chk("par_ok_valid", {63'd0, bus.oData_valid}, 64'd1);
      chk("par_ok_err", {63'd0, bus.oParity_err}, 64'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      push_exp(8'hA5);
      send_bits(8'hA5);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);
      chk("par_bad_err", {63'd0, bus.oParity_err}, 64'd1);
      chk("par_bad_data", {56'd0, bus.oData_out}, 64'hA5);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
      chk("par_clr_err", {63'd0, bus.oParity_err}, 64'd0);
`endif

      idle(3);
      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
